// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters (0 = integer execute,
// 1 = address/aux unit). Round-robin grant, registered operand capture, one
// transaction in flight, registered result with per-requester valid/ready.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid/req_ready[2]  request handshake, bit i = requester i
//   req_*0 / req_*1         request payloads (opcode, in1, imm select, imm, reg)
//   alu_*                   registered drive of every ALU input
//   alu_out                 ALU result
//   rsp_valid/rsp_ready[2]  response handshake, bit i = requester i
//   rsp_data                shared result bus, valid where rsp_valid is set
//   busy                    high whenever not IDLE
module alu_arbiter #(
   parameter int WORD_SIZE    = 32,
   parameter int OPCODE_WIDTH = 6,
   parameter int IMM_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [OPCODE_WIDTH-1:0] req_opcode0,
   input  logic [OPCODE_WIDTH-1:0] req_opcode1,
   input  logic [WORD_SIZE-1:0]    req_in1_0,
   input  logic [WORD_SIZE-1:0]    req_in1_1,
   input  logic                    req_in2_is_imm0,
   input  logic                    req_in2_is_imm1,
   input  logic [IMM_WIDTH-1:0]    req_in2_imm0,
   input  logic [IMM_WIDTH-1:0]    req_in2_imm1,
   input  logic [WORD_SIZE-1:0]    req_in2_reg0,
   input  logic [WORD_SIZE-1:0]    req_in2_reg1,
   output logic [OPCODE_WIDTH-1:0] alu_opcode,
   output logic [WORD_SIZE-1:0]    alu_in1,
   output logic                    alu_in2_is_imm,
   output logic [IMM_WIDTH-1:0]    alu_in2_imm,
   output logic [WORD_SIZE-1:0]    alu_in2_readbus,
   input  logic [WORD_SIZE-1:0]    alu_out,
   output logic [1:0]              rsp_valid,
   input  logic [1:0]              rsp_ready,
   output logic [WORD_SIZE-1:0]    rsp_data,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [OPCODE_WIDTH-1:0] opcode;
      logic [WORD_SIZE-1:0]    in1;
      logic                    is_imm;
      logic [IMM_WIDTH-1:0]    imm;
      logic [WORD_SIZE-1:0]    in2;
   } req_t;

   state_t state, state_nxt;
   logic   rr_ptr;
   logic   owner;
   logic   gnt_vld;
   logic   gnt;
   req_t   req [2];
   req_t   sel;

   assign req[0] = '{req_opcode0, req_in1_0, req_in2_is_imm0, req_in2_imm0, req_in2_reg0};
   assign req[1] = '{req_opcode1, req_in1_1, req_in2_is_imm1, req_in2_imm1, req_in2_reg1};

   // Single requester wins outright; on contention rr_ptr picks.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = 1'b0;
      if (state == IDLE) begin
         unique case (req_valid)
            2'b01:   begin gnt_vld = 1'b1; gnt = 1'b0;   end
            2'b10:   begin gnt_vld = 1'b1; gnt = 1'b1;   end
            2'b11:   begin gnt_vld = 1'b1; gnt = rr_ptr; end
            default: begin gnt_vld = 1'b0; gnt = 1'b0;   end
         endcase
      end
   end

   assign sel       = req[gnt];
   assign req_ready = gnt_vld ? (gnt ? 2'b10 : 2'b01) : 2'b00;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (gnt_vld) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         rr_ptr          <= 1'b0;
         owner           <= 1'b0;
         alu_opcode      <= '0;
         alu_in1         <= '0;
         alu_in2_is_imm  <= 1'b0;
         alu_in2_imm     <= '0;
         alu_in2_readbus <= '0;
         rsp_data        <= '0;
         rsp_valid       <= 2'b00;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: if (gnt_vld) begin
               alu_opcode      <= sel.opcode;
               alu_in1         <= sel.in1;
               alu_in2_is_imm  <= sel.is_imm;
               alu_in2_imm     <= sel.imm;
               alu_in2_readbus <= sel.in2;
               owner           <= gnt;
               rr_ptr          <= ~gnt;
            end
            EXEC: begin
               rsp_data         <= alu_out;
               rsp_valid[owner] <= 1'b1;
            end
            RESP: if (rsp_ready[owner]) rsp_valid <= 2'b00;
            default: ;
         endcase
      end
   end

endmodule
